// File: rtl/imem_fetch_seq_if.sv
// Bundle for the instruction-memory read port, the instruction stream to the
// consumer and the branch-redirect request.
interface imem_fetch_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) ();

    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output redirect_valid,
        output redirect_pc
    );

endinterface

// File: rtl/imem_fetch_seq.sv
// Instruction fetch sequencer: prefetches a program from a 1-cycle-latency
// instruction memory into a small FIFO, with halt detection and branch redirect.
module imem_fetch_seq #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 8,
    parameter int                PROG_LEN   = 128,
    parameter int                FIFO_DEPTH = 4,
    parameter int                HALT_EN    = 1,
    parameter logic [DATA_W-1:0] HALT_WORD  = DATA_W'(32'hFFFF_FFFF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    output logic              o_done,
    output logic [15:0]       o_retired_count,
    imem_fetch_seq_if.master  bus
);

    localparam int                PTR_W       = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   LP_PROG_LEN = (ADDR_W+1)'(PROG_LEN);
    localparam logic [ADDR_W-1:0] LP_LAST_PC  = ADDR_W'(PROG_LEN - 1);
    localparam logic [PTR_W+1:0]  LP_DEPTH    = (PTR_W+2)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic               r_inflight;
    logic               r_discard;
    logic [ADDR_W-1:0]  r_inflight_pc;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic [15:0]        r_retired;
    logic [DATA_W-1:0]  r_mem_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]  r_mem_pc   [FIFO_DEPTH];

    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_start_run;
    logic               w_not_empty;
    logic               w_active;
    logic               w_live_return;
    logic               w_halt;
    logic               w_credit;
    logic               w_redirect_oob;
    logic [PTR_W+1:0]   w_occupancy;

    // Buffered words plus the one outstanding read must never exceed the FIFO,
    // which is what keeps a push from ever landing on a full buffer.
    assign w_occupancy    = {1'b0, r_count} + (PTR_W+2)'(r_inflight);
    assign w_credit       = w_occupancy < LP_DEPTH;
    assign w_not_empty    = r_count != '0;
    assign w_active       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_live_return  = r_inflight && !r_discard;
    assign w_halt         = (HALT_EN != 0) && w_live_return && (bus.imem_rdata == HALT_WORD);
    assign w_redirect_oob = {1'b0, bus.redirect_pc} >= LP_PROG_LEN;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Redirect outranks everything else; a return landing in that cycle is dropped.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_flush      = 1'b0;
        w_start_run  = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_start_run  = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN, S_DRAIN: begin
                if (bus.redirect_valid) begin
                    w_flush      = 1'b1;
                    w_next_state = w_redirect_oob ? S_DRAIN : S_RUN;
                end else begin
                    w_pop  = w_not_empty && bus.instr_ready;
                    w_push = w_live_return && !w_halt;
                    if (r_state == S_RUN) begin
                        w_issue = w_credit;
                        if ((w_credit && (r_fetch_pc == LP_LAST_PC)) || w_halt) begin
                            w_next_state = S_DRAIN;
                        end
                    end else if (!w_not_empty && !r_inflight) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // A read issued alongside a detected halt is tagged so its return is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= '0;
            r_inflight    <= 1'b0;
            r_discard     <= 1'b0;
            r_inflight_pc <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_retired     <= '0;
        end else begin
            r_inflight <= w_issue;
            r_discard  <= w_issue && w_halt;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
            end
            if (w_start_run) begin
                r_fetch_pc <= '0;
                r_retired  <= '0;
            end else if (w_flush) begin
                r_fetch_pc <= bus.redirect_pc;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                    if (r_retired != 16'hFFFF) begin
                        r_retired <= r_retired + 16'd1;
                    end
                end
                unique case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                    2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= bus.imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_inflight_pc;
        end
    end

    // Head outputs read as zero whenever the buffer is empty, so storage needs no reset.
    assign bus.imem_en     = w_issue;
    assign bus.imem_addr   = r_fetch_pc;
    assign bus.instr_valid = w_not_empty && !(bus.redirect_valid && w_active);
    assign bus.instr       = w_not_empty ? r_mem_data[r_rd_ptr] : '0;
    assign bus.instr_pc    = w_not_empty ? r_mem_pc[r_rd_ptr] : '0;
    assign o_done          = r_state == S_DONE;
    assign o_retired_count = r_retired;

endmodule
